// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    localparam int unsigned MIN_DIV_DEF = 2;
    localparam int unsigned CLAMP_W     = 32;

    // Raise any divisor below the legal minimum up to that minimum.
    function automatic logic [CLAMP_W-1:0] clamp_div(
        input logic [CLAMP_W-1:0] div,
        input logic [CLAMP_W-1:0] min_div
    );
        return (div < min_div) ? min_div : div;
    endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// Single-bit rising-edge detector with a registered history bit.
module rising_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise_c
);

    logic hist_q;
    logic hist_d;

    always_comb begin
        hist_d = din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign rise_c = din & ~hist_q;

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider with free-run and single-step modes;
// divisor changes are applied only at period boundaries.
module clock_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH       = 28,
    parameter int unsigned DEFAULT_DIV = 5000000,
    parameter int unsigned MIN_DIV     = MIN_DIV_DEF
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             step_req,
    input  logic             load,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             clock_out,
    output logic             tick,
    output logic             busy
);

    localparam logic [WIDTH-1:0] RST_DIV =
        WIDTH'(clamp_div(CLAMP_W'(DEFAULT_DIV), CLAMP_W'(MIN_DIV)));

    state_e           state_q,      state_d;
    logic [WIDTH-1:0] cnt_q,        cnt_d;
    logic [WIDTH-1:0] div_cur_q,    div_cur_d;
    logic [WIDTH-1:0] div_shadow_q, div_shadow_d;
    logic             clock_out_q,  clock_out_d;
    logic             tick_q,       tick_d;
    logic             busy_q,       busy_d;

    logic             step_rise_c;
    logic             last_c;
    logic [WIDTH-1:0] half_c;
    logic [WIDTH-1:0] cnt_inc_c;
    logic [WIDTH-1:0] load_div_c;

    rising_edge_detect u_step_edge (
        .clk    (clock_in),
        .reset  (reset),
        .din    (step_req),
        .rise_c (step_rise_c)
    );

    assign load_div_c = WIDTH'(clamp_div(CLAMP_W'(divisor_in), CLAMP_W'(MIN_DIV)));
    assign last_c     = (cnt_q == (div_cur_q - WIDTH'(1)));
    assign half_c     = div_cur_q >> 1;
    assign cnt_inc_c  = cnt_q + WIDTH'(1);

    // Next-state, counter and output computation; outputs are the registered
    // image of the next counter value so clock_out/tick/busy stay aligned.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_cur_d    = div_cur_q;
        div_shadow_d = load ? load_div_c : div_shadow_q;
        clock_out_d  = 1'b0;
        tick_d       = 1'b0;
        busy_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                div_cur_d = div_shadow_d;
                if (!mode && enable) begin
                    state_d     = ST_RUN;
                    clock_out_d = 1'b1;
                    tick_d      = 1'b1;
                    busy_d      = 1'b1;
                end else if (mode && step_rise_c) begin
                    state_d     = ST_STEP;
                    clock_out_d = 1'b1;
                    tick_d      = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            ST_RUN, ST_STEP: begin
                if (last_c) begin
                    // Boundary: adopt the pending divisor and either rewrap or stop.
                    cnt_d     = '0;
                    div_cur_d = div_shadow_d;
                    if ((state_q == ST_RUN) && enable && !mode) begin
                        clock_out_d = 1'b1;
                        tick_d      = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d       = cnt_inc_c;
                    clock_out_d = (cnt_inc_c < half_c);
                    busy_d      = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            div_cur_q    <= RST_DIV;
            div_shadow_q <= RST_DIV;
            clock_out_q  <= 1'b0;
            tick_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_cur_q    <= div_cur_d;
            div_shadow_q <= div_shadow_d;
            clock_out_q  <= clock_out_d;
            tick_q       <= tick_d;
            busy_q       <= busy_d;
        end
    end

    assign clock_out = clock_out_q;
    assign tick      = tick_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed self-checking bench for clock_divider_prog (DEFAULT_DIV=4).
module tb_clock_divider_prog;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             mode;
    logic             step_req;
    logic             load;
    logic [WIDTH-1:0] divisor_in;
    logic             clock_out;
    logic             tick;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    clock_divider_prog #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (4),
        .MIN_DIV     (2)
    ) dut (
        .clock_in   (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .step_req   (step_req),
        .load       (load),
        .divisor_in (divisor_in),
        .clock_out  (clock_out),
        .tick       (tick),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs changed on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic e_clk, input logic e_tick, input logic e_busy);
        n_cmp++;
        assert ({clock_out, tick, busy} === {e_clk, e_tick, e_busy}) else begin
            n_bad++;
            $error("FAIL %s: clk/tick/busy observed=%b%b%b expected=%b%b%b",
                   tag, clock_out, tick, busy, e_clk, e_tick, e_busy);
        end
    endtask

    // Check n free-running cycles of a div-period, first observed phase k0.
    task automatic run_cycles(input string tag, input int div, input int k0, input int n);
        int k;
        k = k0;
        for (int i = 0; i < n; i++) begin
            cyc();
            chk(tag, (k < div / 2), (k == 0), 1'b1);
            k = (k + 1) % div;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; mode = 1'b0; step_req = 1'b0;
        load = 1'b0; divisor_in = '0;
        cyc(); cyc();
        chk("reset_state", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(); chk("idle_no_enable", 1'b0, 1'b0, 1'b0);

        // Free-run with default divisor 4.
        enable = 1'b1;
        run_cycles("div4_free", 4, 0, 8);

        // Load 6 mid-period: current div-4 period completes unchanged.
        cyc(); chk("div4_c0", 1'b1, 1'b1, 1'b1);
        cyc(); chk("div4_c1", 1'b1, 1'b0, 1'b1);
        load = 1'b1; divisor_in = 8'd6;
        cyc(); load = 1'b0; chk("div4_c2_loaded", 1'b0, 1'b0, 1'b1);
        cyc(); chk("div4_c3_loaded", 1'b0, 1'b0, 1'b1);
        run_cycles("div6", 6, 0, 12);

        // Load 0 on a boundary cycle: clamps to 2 and applies to the next period.
        load = 1'b1; divisor_in = 8'd0;
        cyc(); load = 1'b0; chk("div2_clamp_c0", 1'b1, 1'b1, 1'b1);
        run_cycles("div2_clamp", 2, 1, 3);

        // Load 5 on a boundary: 2 high, 3 low.
        load = 1'b1; divisor_in = 8'd5;
        cyc(); load = 1'b0; chk("div5_c0", 1'b1, 1'b1, 1'b1);
        run_cycles("div5", 5, 1, 9);

        // Two loads in one period: the later one wins.
        cyc(); chk("lw_c0", 1'b1, 1'b1, 1'b1);
        load = 1'b1; divisor_in = 8'd7;
        cyc(); chk("lw_c1", 1'b1, 1'b0, 1'b1);
        divisor_in = 8'd4;
        cyc(); load = 1'b0; chk("lw_c2", 1'b0, 1'b0, 1'b1);
        cyc(); chk("lw_c3", 1'b0, 1'b0, 1'b1);
        cyc(); chk("lw_c4", 1'b0, 1'b0, 1'b1);
        run_cycles("div4_lastwins", 4, 0, 4);

        // div 8, drop enable at counter 2: period completes, then idle.
        load = 1'b1; divisor_in = 8'd8;
        cyc(); load = 1'b0; chk("div8_c0", 1'b1, 1'b1, 1'b1);
        cyc(); chk("div8_c1", 1'b1, 1'b0, 1'b1);
        cyc(); chk("div8_c2", 1'b1, 1'b0, 1'b1);
        enable = 1'b0;
        run_cycles("div8_drain", 8, 3, 5);
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("div8_stopped", 1'b0, 1'b0, 1'b0);
        end

        // Single-step, div 4 loaded while idle (takes effect immediately).
        mode = 1'b1;
        load = 1'b1; divisor_in = 8'd4;
        cyc(); load = 1'b0; chk("step_idle", 1'b0, 1'b0, 1'b0);
        step_req = 1'b1;
        run_cycles("step1", 4, 0, 3);
        step_req = 1'b0;
        cyc(); chk("step1_c3", 1'b0, 1'b0, 1'b1);
        cyc(); chk("step1_done", 1'b0, 1'b0, 1'b0);
        cyc(); chk("step1_stay", 1'b0, 1'b0, 1'b0);

        // Rise during STEP is ignored, not queued.
        step_req = 1'b1;
        cyc(); step_req = 1'b0; chk("step2_c0", 1'b1, 1'b1, 1'b1);
        cyc(); chk("step2_c1", 1'b1, 1'b0, 1'b1);
        step_req = 1'b1;
        cyc(); step_req = 1'b0; chk("step2_c2", 1'b0, 1'b0, 1'b1);
        cyc(); chk("step2_c3", 1'b0, 1'b0, 1'b1);
        cyc(); chk("step2_done", 1'b0, 1'b0, 1'b0);
        cyc(); chk("step2_no_queue", 1'b0, 1'b0, 1'b0);

        // Rise on the boundary cycle is ignored; holding high gives no new step.
        step_req = 1'b1;
        cyc(); step_req = 1'b0; chk("step3_c0", 1'b1, 1'b1, 1'b1);
        cyc(); chk("step3_c1", 1'b1, 1'b0, 1'b1);
        cyc(); chk("step3_c2", 1'b0, 1'b0, 1'b1);
        cyc(); chk("step3_c3", 1'b0, 1'b0, 1'b1);
        step_req = 1'b1;
        cyc(); chk("step3_boundary_rise", 1'b0, 1'b0, 1'b0);
        cyc(); chk("step3_held_high", 1'b0, 1'b0, 1'b0);
        step_req = 1'b0;
        enable = 1'b1;
        cyc(); chk("step_mode_ignores_enable", 1'b0, 1'b0, 1'b0);

        // Reset at counter 1 of a div-6 period; divisor reverts to 4.
        mode = 1'b0; enable = 1'b0;
        load = 1'b1; divisor_in = 8'd6;
        cyc(); load = 1'b0; chk("rst_pre_idle", 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        cyc(); chk("rst_div6_c0", 1'b1, 1'b1, 1'b1);
        cyc(); chk("rst_div6_c1", 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        cyc(); chk("rst_mid_period", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        run_cycles("after_reset_div4", 4, 0, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
Parametrised, runtime-programmable successor to the fixed-divisor clock divider that drives the RISC-V core's slow clock on the FPGA board.
- Divides clock_in by a divisor loadable at run time, with divisor changes taking effect only at period boundaries (no runt pulses).
- Adds a single-step mode so a push-button can advance the processor exactly one slow-clock period.
- Adds a one-cycle tick output marking each period start.

Parameters:
WIDTH, 28, bit width of counter and divisor
DEFAULT_DIV, 5000000, divisor in effect after reset
MIN_DIV, 2, smallest legal divisor; smaller requests are clamped to this

Ports:
clock_in  input  1  FPGA board clock
reset  input  1  synchronous, active-high reset
enable  input  1  free-run request (mode=0)
mode  input  1  0 = free-run, 1 = single-step
step_req  input  1  step request, level; rising edge is detected internally (already synchronised/debounced upstream)
load  input  1  one-cycle strobe: capture divisor_in
divisor_in  input  WIDTH  new divisor
clock_out  output  1  divided clock, registered
tick  output  1  one-cycle pulse on the clock_in cycle where clock_out rises
busy  output  1  high while a period is in progress (state != IDLE)

Behaviour:
- Reset, synchronous: state=IDLE, counter=0, div_cur=div_shadow=DEFAULT_DIV, clock_out=0, tick=0, busy=0, step edge-detector history=0.
- Clamp: any captured divisor below MIN_DIV is stored as MIN_DIV. half = div_cur >> 1.
- Period shape: counter runs 0..div_cur-1. clock_out=1 for counter < half, else 0.
  - Odd divisors have the longer low phase; div=5 gives 2 high, 3 low.
- Registered output timing: counter, clock_out and tick are all registers updated together, so clock_out always equals (busy && counter<half) in the same cycle.
- tick=1 exactly in cycles where counter==0 and busy=1.
- Load: on load=1, div_shadow <= clamp(divisor_in).
  - div_cur <= div_shadow at the boundary cycle (counter==div_cur-1), or immediately when in IDLE.
  - load on the boundary cycle itself: the new value is used for the very next period.
  - Last load before a boundary wins.
- State machine IDLE / RUN / STEP:
  - IDLE: counter=0, clock_out=0.
    - mode=0 && enable goes to RUN; the first active cycle has counter=0, clock_out=1, tick=1.
    - mode=1 && step_rise goes to STEP, with the same first-cycle behaviour.
    - Both conditions are mutually exclusive by mode.
  - RUN: counter increments and wraps at div_cur-1 to 0.
    - At a boundary, (!enable || mode==1) moves to IDLE; otherwise wrap and start a new period.
    - Dropping enable mid-period always completes the current period; no truncation.
  - STEP: one full period, then IDLE at the boundary.
    - step_rise during STEP is ignored, not queued.
    - step_rise on the same cycle as STEP returns to IDLE is also ignored.
    - A new step needs a fresh rising edge.
- Reset mid-period: immediate return to reset state on the next edge. clock_out may be truncated; this is acceptable.
- Counter never exceeds div_cur-1; div_cur is never below MIN_DIV.

Decomposition:
- Package clkdiv_pkg:
  - state enum (IDLE, RUN, STEP)
  - clamp function
  - MIN_DIV default constant
- Sub-module rising_edge_detect (1-bit input, synchronous active-high reset, registered history, combinational rise output) for step_req.
- Rest is flat RTL.

Test Plan:
- DEFAULT_DIV=4; reset then enable=1, mode=0 -> clock_out pattern 1,1,0,0 repeating; tick on every 4th cycle; busy=1.
- Free-run div=4; load divisor_in=6 at counter=1 -> current period finishes with 4 cycles, next periods are 3 high / 3 low; no short pulse.
- load divisor_in=0, then divisor_in=5 -> 0 clamps to 2 (pattern 1,0); 5 gives 2 high, 3 low.
- mode=1, div=4, step_req pulsed 3 cycles high -> exactly one period 1,1,0,0, then IDLE with clock_out=0, busy=0. A second rise mid-period is ignored; a rise after IDLE gives one more period.
- Free-run div=8; drop enable at counter=2 -> clock_out completes through counter=7, then stays 0; tick absent afterwards.
- Assert reset at counter=1 of a div=6 period -> next cycle clock_out=0, busy=0, divisor back to DEFAULT_DIV.
